hello_world_led: RTL and testbench

- Power-on "hello world" RGB LED sequencer for the Tang Nano board.
- A clock prescaler produces a slow tick, and a 7-state colour FSM steps through primary and secondary colours on that tick.
- An optional PWM stage dims the LEDs.
- Drives the three on-board RGB LED pins directly; no other interfaces.

---
 rtl/hello_world_led.sv | 98 +++++++++
 tb/tb_hello_world_led.sv | 89 ++++++++
 2 files changed

// File: rtl/hello_world_led.sv
// Power-on RGB LED sequencer: a prescaler tick steps a seven-colour FSM,
// and a 16-step PWM gate dims the registered LED pins.
module hello_world_led #(
  parameter int TICK_DIV   = 24000,
  parameter int HOLD_TICKS = 1,
  parameter int PWM_DUTY   = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  output logic led_r,
  output logic led_g,
  output logic led_b
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  // Five bits so that a duty of 16 keeps the LEDs permanently on
  localparam logic [4:0]    DUTY      = 5'(PWM_DUTY);

  localparam logic [2:0] S_RED     = 3'd0;
  localparam logic [2:0] S_GREEN   = 3'd1;
  localparam logic [2:0] S_BLUE    = 3'd2;
  localparam logic [2:0] S_YELLOW  = 3'd3;
  localparam logic [2:0] S_CYAN    = 3'd4;
  localparam logic [2:0] S_MAGENTA = 3'd5;
  localparam logic [2:0] S_WHITE   = 3'd6;

  logic [PW-1:0] prescaler;
  logic [HW-1:0] hold_cnt;
  logic [3:0]    pwm_cnt;
  logic [2:0]    state;
  logic [2:0]    state_next;
  logic [2:0]    colour;
  logic          tick;
  logic          advance;
  logic          pwm_on;

  always_comb begin
    tick    = (prescaler == PRE_LAST);
    advance = tick && (hold_cnt == HOLD_LAST);
    pwm_on  = ({1'b0, pwm_cnt} < DUTY);
  end

  // Colour bits are {r,g,b}, logically on
  always_comb begin
    colour = 3'b100;
    case (state)
      S_RED:     colour = 3'b100;
      S_GREEN:   colour = 3'b010;
      S_BLUE:    colour = 3'b001;
      S_YELLOW:  colour = 3'b110;
      S_CYAN:    colour = 3'b011;
      S_MAGENTA: colour = 3'b101;
      S_WHITE:   colour = 3'b111;
      default:   colour = 3'b100;
    endcase
  end

  always_comb begin
    state_next = S_RED;
    case (state)
      S_RED:     state_next = S_GREEN;
      S_GREEN:   state_next = S_BLUE;
      S_BLUE:    state_next = S_YELLOW;
      S_YELLOW:  state_next = S_CYAN;
      S_CYAN:    state_next = S_MAGENTA;
      S_MAGENTA: state_next = S_WHITE;
      S_WHITE:   state_next = S_RED;
      default:   state_next = S_RED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler <= '0;
      hold_cnt  <= '0;
      pwm_cnt   <= '0;
      state     <= S_RED;
      {led_r, led_g, led_b} <= {3{ACTIVE_LOW}};
    end else begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
      pwm_cnt   <= pwm_cnt + 4'd1;
      if (tick) begin
        hold_cnt <= advance ? '0 : hold_cnt + HW'(1);
      end
      if (advance) begin
        state <= state_next;
      end
      // Pins reflect the state and PWM phase present before this edge
      {led_r, led_g, led_b} <= (colour & {3{pwm_on}}) ^ {3{ACTIVE_LOW}};
    end
  end

endmodule

// File: tb/tb_hello_world_led.sv
// Bench for hello_world_led: six differently parameterised instances are
// compared every cycle against an arithmetic model of the colour sequence.
module tb_hello_world_led;

  localparam int N = 6;
  localparam int TDV [N] = '{24000, 4, 1000, 1000, 4, 3};
  localparam int HTV [N] = '{1,     2, 1,    1,    1, 3};
  localparam int DTV [N] = '{16,    16, 8,   0,    16, 5};
  localparam bit ALV [N] = '{1'b1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  // RED GREEN BLUE YELLOW CYAN MAGENTA WHITE, as {r,g,b}
  localparam logic [20:0] SEQ = {3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b101, 3'b111};

  logic           clk = 1'b0;
  logic [N-1:0]   rst_n;
  logic [3*N-1:0] pins;
  int             checks = 0;
  int             errors = 0;
  int             k [N];
  bit             did_mid = 1'b0;

  always #5 clk = ~clk;

  hello_world_led #(.TICK_DIV(TDV[0]), .HOLD_TICKS(HTV[0]), .PWM_DUTY(DTV[0]), .ACTIVE_LOW(ALV[0]))
    u0 (.clk(clk), .rst_n(rst_n[0]), .led_r(pins[2]),  .led_g(pins[1]),  .led_b(pins[0]));
  hello_world_led #(.TICK_DIV(TDV[1]), .HOLD_TICKS(HTV[1]), .PWM_DUTY(DTV[1]), .ACTIVE_LOW(ALV[1]))
    u1 (.clk(clk), .rst_n(rst_n[1]), .led_r(pins[5]),  .led_g(pins[4]),  .led_b(pins[3]));
  hello_world_led #(.TICK_DIV(TDV[2]), .HOLD_TICKS(HTV[2]), .PWM_DUTY(DTV[2]), .ACTIVE_LOW(ALV[2]))
    u2 (.clk(clk), .rst_n(rst_n[2]), .led_r(pins[8]),  .led_g(pins[7]),  .led_b(pins[6]));
  hello_world_led #(.TICK_DIV(TDV[3]), .HOLD_TICKS(HTV[3]), .PWM_DUTY(DTV[3]), .ACTIVE_LOW(ALV[3]))
    u3 (.clk(clk), .rst_n(rst_n[3]), .led_r(pins[11]), .led_g(pins[10]), .led_b(pins[9]));
  hello_world_led #(.TICK_DIV(TDV[4]), .HOLD_TICKS(HTV[4]), .PWM_DUTY(DTV[4]), .ACTIVE_LOW(ALV[4]))
    u4 (.clk(clk), .rst_n(rst_n[4]), .led_r(pins[14]), .led_g(pins[13]), .led_b(pins[12]));
  hello_world_led #(.TICK_DIV(TDV[5]), .HOLD_TICKS(HTV[5]), .PWM_DUTY(DTV[5]), .ACTIVE_LOW(ALV[5]))
    u5 (.clk(clk), .rst_n(rst_n[5]), .led_r(pins[17]), .led_g(pins[16]), .led_b(pins[15]));

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", tag, got, exp);
    end
  endtask

  // Expected pins after the k-th edge since reset release (k=0: in reset)
  function automatic logic [2:0] model(input int kk, input int td, input int ht,
                                       input int duty, input bit al);
    int          idx;
    int          phase;
    logic [20:0] seq;
    logic [2:0]  col;
    if (kk == 0) return {3{al}};
    seq   = SEQ;
    idx   = ((kk - 1) / (td * ht)) % 7;
    phase = (kk - 1) % 16;
    col   = seq[20 - 3*idx -: 3];
    if (phase >= duty) col = 3'b000;
    return col ^ {3{al}};
  endfunction

  initial begin
    rst_n = '0;
    for (int i = 0; i < N; i++) k[i] = 0;
    @(negedge clk);
    for (int cyc = 0; cyc < 30000; cyc++) begin
      @(posedge clk);
      for (int i = 0; i < N; i++) k[i] = rst_n[i] ? k[i] + 1 : 0;
      #1;
      for (int i = 0; i < N; i++)
        chk($sformatf("u%0d_cyc%0d_k%0d", i, cyc, k[i]), pins[3*i +: 3],
            model(k[i], TDV[i], HTV[i], DTV[i], ALV[i]));
      @(negedge clk);
      if (cyc < 4) begin
        rst_n = '0;
      end else begin
        rst_n[3:0] = 4'hF;
        if (k[4] == 10 && !did_mid) begin
          rst_n[4] = 1'b0;
          did_mid  = 1'b1;
        end else begin
          rst_n[4] = ($urandom_range(0, 299) != 0);
        end
        rst_n[5] = ($urandom_range(0, 199) != 0);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
